// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock and sequencing controller for the cpu3
// five-stage datapath (IF, ID, EX, MEM, WB).
//
// Tracks register-file writes in flight past ID, stalls ID on read-after-write
// hazards, squashes wrong-path instructions after a redirect, and drains the
// pipeline on halt/exception before raising the sticky terminal outputs.
//
// Ports:
//   clk, rst_                 clock, asynchronous active-low reset
//   id_valid                  ID holds a real instruction
//   id_r1_addr, id_r2_addr    source register addresses
//   id_use_r1, id_use_r2      instruction reads the matching source
//   id_rw_, id_waddr          active-low write enable and destination
//   id_halt, id_exception     ID instruction is halt / illegal
//   redirect                  taken branch or jump resolved this cycle
//   stall                     hold PC and instruction register
//   bubble                    force ID/EX controls to NOP
//   flush                     squash the instruction in IF/ID
//   halt, exception           sticky, pipeline drained after halt/exception
//   stall_cnt                 saturating count of stall cycles
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal issue; hazards stall, redirects flush
// ST_DRAIN | halt/exception accepted; hold ID until all slots are empty
// ST_DONE  | pipeline empty; terminal output raised and held until reset

module hazard_ctrl #(
  parameter int REG_ADDR_BITS = 5,
  parameter int DEPTH         = 3,
  parameter int WB_BYPASS     = 1,
  parameter int FLUSH_CYCLES  = 2,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     id_valid,
  input  logic [REG_ADDR_BITS-1:0] id_r1_addr,
  input  logic [REG_ADDR_BITS-1:0] id_r2_addr,
  input  logic                     id_use_r1,
  input  logic                     id_use_r2,
  input  logic                     id_rw_,
  input  logic [REG_ADDR_BITS-1:0] id_waddr,
  input  logic                     id_halt,
  input  logic                     id_exception,
  input  logic                     redirect,
  output logic                     stall,
  output logic                     bubble,
  output logic                     flush,
  output logic                     halt,
  output logic                     exception,
  output logic [CNT_BITS-1:0]      stall_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  // With write-through in WB the oldest slot can never cause a hazard.
  localparam int CHK     = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;
  localparam int FC_BITS = $clog2(FLUSH_CYCLES + 1);

  state_t                   state, state_nxt;
  logic [DEPTH-1:0]         slot_v;
  logic [REG_ADDR_BITS-1:0] slot_waddr [DEPTH];
  logic [FC_BITS-1:0]       flush_cnt;
  logic                     exc_pend;
  logic                     hazard;
  logic                     issue;
  logic                     slot0_v;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < CHK; i++) begin
      if (slot_v[i] && id_use_r1 && (id_r1_addr != '0) && (id_r1_addr == slot_waddr[i]))
        hazard = 1'b1;
      if (slot_v[i] && id_use_r2 && (id_r2_addr != '0) && (id_r2_addr == slot_waddr[i]))
        hazard = 1'b1;
    end
    hazard = hazard & id_valid;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    flush     = redirect | (flush_cnt != '0);
    case (state)
      ST_RUN: begin
        // A squashed instruction is not worth stalling for.
        stall = hazard & ~flush;
        // Halt/exception in the branch shadow is wrong-path and ignored.
        if (id_valid && (id_halt || id_exception) && !flush)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (slot_v == '0)
          state_nxt = ST_DONE;
      end
      ST_DONE: stall = 1'b1;
      default: state_nxt = ST_RUN;
    endcase
    bubble  = stall | flush;
    issue   = id_valid & ~stall & ~bubble & (state == ST_RUN);
    slot0_v = issue & ~id_rw_ & (id_waddr != '0);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= ST_RUN;
      slot_v    <= '0;
      for (int i = 0; i < DEPTH; i++) slot_waddr[i] <= '0;
      flush_cnt <= '0;
      exc_pend  <= 1'b0;
      halt      <= 1'b0;
      exception <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;

      slot_v        <= {slot_v[DEPTH-2:0], slot0_v};
      slot_waddr[0] <= id_waddr;
      for (int i = 1; i < DEPTH; i++) slot_waddr[i] <= slot_waddr[i-1];

      if (redirect)
        flush_cnt <= FC_BITS'(FLUSH_CYCLES - 1);
      else if (flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;

      // Exception wins when the instruction is both halt and illegal.
      if (state == ST_RUN && state_nxt == ST_DRAIN)
        exc_pend <= id_exception;

      if (state == ST_DONE) begin
        if (exc_pend) exception <= 1'b1;
        else          halt      <= 1'b1;
      end

      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int RAB = 5;
  localparam int DEPTH = 3;
  localparam int WB = 1;
  localparam int FLUSHC = 2;
  localparam int CNTB = 16;

  logic clk = 1'b0;
  logic rst_;
  logic id_valid, id_use_r1, id_use_r2, id_rw_, id_halt, id_exception, redirect;
  logic [RAB-1:0] id_r1_addr, id_r2_addr, id_waddr;
  logic stall, bubble, flush, halt, exception;
  logic [CNTB-1:0] stall_cnt;

  int nchecks = 0;
  int nerr = 0;

  hazard_ctrl #(.REG_ADDR_BITS(RAB), .DEPTH(DEPTH), .WB_BYPASS(WB),
                .FLUSH_CYCLES(FLUSHC), .CNT_BITS(CNTB)) dut (
    .clk(clk), .rst_(rst_), .id_valid(id_valid), .id_r1_addr(id_r1_addr),
    .id_r2_addr(id_r2_addr), .id_use_r1(id_use_r1), .id_use_r2(id_use_r2),
    .id_rw_(id_rw_), .id_waddr(id_waddr), .id_halt(id_halt),
    .id_exception(id_exception), .redirect(redirect), .stall(stall),
    .bubble(bubble), .flush(flush), .halt(halt), .exception(exception),
    .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  // Reference model: timestamps per register and per event, not pipeline slots.
  int cyc = 0;
  int busy_until [32];
  int last_write, flush_until, halt_cycle, out_cycle, exp_cnt;
  bit exc_flag;
  bit e_stall, e_bubble, e_flush, e_halt, e_exc, e_issue;

  task automatic model_reset();
    foreach (busy_until[i]) busy_until[i] = -1000;
    last_write = -1000; flush_until = -1000; halt_cycle = -1;
    out_cycle = 0; exc_flag = 0; exp_cnt = 0;
  endtask

  task automatic model_eval();
    bit flushing, hz, draining;
    flushing = redirect || (cyc <= flush_until);
    draining = (halt_cycle >= 0) && (cyc > halt_cycle);
    hz = id_valid && ((id_use_r1 && id_r1_addr != 0 && busy_until[id_r1_addr] >= cyc) ||
                      (id_use_r2 && id_r2_addr != 0 && busy_until[id_r2_addr] >= cyc));
    e_stall  = draining || (hz && !flushing);
    e_flush  = flushing;
    e_bubble = e_stall || flushing;
    e_issue  = id_valid && !e_bubble;
    e_halt   = (halt_cycle >= 0) && !exc_flag && (cyc >= out_cycle);
    e_exc    = (halt_cycle >= 0) && exc_flag && (cyc >= out_cycle);
  endtask

  task automatic model_commit();
    if (e_stall && exp_cnt < 65535) exp_cnt++;
    if (e_issue && !id_rw_ && id_waddr != 0) begin
      // A write is visible to hazard checks for DEPTH-WB cycles after issue.
      busy_until[id_waddr] = cyc + DEPTH - WB;
      last_write = cyc;
    end
    if (halt_cycle < 0 && id_valid && (id_halt || id_exception) && !e_flush) begin
      halt_cycle = cyc;
      exc_flag = id_exception;
      out_cycle = (cyc + 3 > last_write + DEPTH + 3) ? cyc + 3 : last_write + DEPTH + 3;
    end
    if (redirect) flush_until = cyc + FLUSHC - 1;
    cyc++;
  endtask

  task automatic set_idle();
    id_valid = 0; id_use_r1 = 0; id_use_r2 = 0; id_rw_ = 1; id_halt = 0;
    id_exception = 0; redirect = 0; id_r1_addr = 0; id_r2_addr = 0; id_waddr = 0;
  endtask

  task automatic do_reset();
    set_idle(); rst_ = 0; #1; model_reset();
    repeat (2) @(posedge clk);
    #1 rst_ = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_instr(input int wa);
    set_idle(); id_valid = 1; id_rw_ = 0; id_waddr = RAB'(wa);
  endtask

  task automatic read_instr(input int ra);
    set_idle(); id_valid = 1; id_use_r1 = 1; id_r1_addr = RAB'(ra);
  endtask

  task automatic test_reset();
    set_idle(); rst_ = 0; #1;
    nchecks++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b want 0", stall); end
    nchecks++; if (bubble !== 1'b0) begin nerr++; $display("FAIL reset_bubble: got %b want 0", bubble); end
    nchecks++; if (flush !== 1'b0) begin nerr++; $display("FAIL reset_flush: got %b want 0", flush); end
    nchecks++; if (halt !== 1'b0 || exception !== 1'b0) begin nerr++; $display("FAIL reset_term: got %b%b want 00", halt, exception); end
    nchecks++; if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_ = 1;
  endtask

  task automatic test_raw();
    do_reset();
    write_instr(3);
    @(negedge clk);
    nchecks++; if (stall !== 1'b0) begin nerr++; $display("FAIL raw_write_stall: got %b want 0", stall); end
    tick();
    read_instr(3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nchecks++; if (stall !== 1'b1 || bubble !== 1'b1) begin nerr++; $display("FAIL raw_hold%0d: got stall=%b bubble=%b want 1 1", k, stall, bubble); end
      tick();
    end
    @(negedge clk);
    nchecks++; if (stall !== 1'b0 || bubble !== 1'b0) begin nerr++; $display("FAIL raw_issue: got stall=%b bubble=%b want 0 0", stall, bubble); end
    nchecks++; if (stall_cnt !== 16'd2) begin nerr++; $display("FAIL raw_cnt: got %0d want 2", stall_cnt); end
    tick();
  endtask

  task automatic test_no_hazard();
    do_reset();
    write_instr(0); tick();
    read_instr(0); id_use_r2 = 1; @(negedge clk);
    nchecks++; if (stall !== 1'b0) begin nerr++; $display("FAIL r0_stall: got %b want 0", stall); end
    tick();
    write_instr(5); tick();
    read_instr(6); @(negedge clk);
    nchecks++; if (stall !== 1'b0) begin nerr++; $display("FAIL r5r6_stall: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    write_instr(7); tick();
    read_instr(7); redirect = 1; @(negedge clk);
    nchecks++; if (flush !== 1'b1 || bubble !== 1'b1 || stall !== 1'b0) begin nerr++; $display("FAIL redir_c0: got f=%b b=%b s=%b want 1 1 0", flush, bubble, stall); end
    tick();
    set_idle(); @(negedge clk);
    nchecks++; if (flush !== 1'b1 || stall !== 1'b0) begin nerr++; $display("FAIL redir_c1: got f=%b s=%b want 1 0", flush, stall); end
    tick();
    @(negedge clk);
    nchecks++; if (flush !== 1'b0) begin nerr++; $display("FAIL redir_c2: got f=%b want 0", flush); end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    set_idle(); id_valid = 1; id_halt = 1; @(negedge clk);
    nchecks++; if (stall !== 1'b0) begin nerr++; $display("FAIL halt_issue_stall: got %b want 0", stall); end
    tick();
    set_idle();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      nchecks++; if (stall !== 1'b1) begin nerr++; $display("FAIL halt_stall_t%0d: got %b want 1", k, stall); end
      nchecks++; if (halt !== (k >= 3) || exception !== 1'b0) begin nerr++; $display("FAIL halt_out_t%0d: got h=%b e=%b want %b 0", k, halt, exception, k >= 3); end
      tick();
    end
  endtask

  task automatic test_exc_both();
    do_reset();
    set_idle(); id_valid = 1; id_halt = 1; id_exception = 1; tick();
    set_idle(); repeat (4) tick();
    @(negedge clk);
    nchecks++; if (exception !== 1'b1 || halt !== 1'b0) begin nerr++; $display("FAIL exc_both: got h=%b e=%b want 0 1", halt, exception); end
    tick();
  endtask

  task automatic test_halt_in_flush();
    do_reset();
    set_idle(); id_valid = 1; id_halt = 1; redirect = 1; tick();
    redirect = 0; tick();
    set_idle(); repeat (4) tick();
    @(negedge clk);
    nchecks++; if (stall !== 1'b0 || halt !== 1'b0) begin nerr++; $display("FAIL halt_shadow: got s=%b h=%b want 0 0", stall, halt); end
    tick();
  endtask

  task automatic test_reset_drain();
    do_reset();
    set_idle(); id_valid = 1; id_halt = 1; tick();
    set_idle(); @(negedge clk);
    nchecks++; if (stall !== 1'b1) begin nerr++; $display("FAIL drain_stall: got %b want 1", stall); end
    #2 rst_ = 0; #1;
    nchecks++; if (stall !== 1'b0 || halt !== 1'b0 || stall_cnt !== 16'd0) begin nerr++; $display("FAIL drain_rst: got s=%b h=%b cnt=%0d want 0 0 0", stall, halt, stall_cnt); end
    model_reset();
    @(posedge clk); #1 rst_ = 1;
    write_instr(9); @(negedge clk);
    nchecks++; if (stall !== 1'b0) begin nerr++; $display("FAIL drain_resume: got %b want 0", stall); end
    tick();
    read_instr(9); @(negedge clk);
    nchecks++; if (stall !== 1'b1) begin nerr++; $display("FAIL drain_resume_haz: got %b want 1", stall); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if (halt_cycle >= 0 && cyc > out_cycle + 2) do_reset();
      id_valid     = ($urandom_range(0, 3) != 0);
      id_r1_addr   = RAB'($urandom_range(0, 7));
      id_r2_addr   = RAB'($urandom_range(0, 7));
      id_waddr     = RAB'($urandom_range(0, 7));
      id_use_r1    = $urandom_range(0, 1);
      id_use_r2    = $urandom_range(0, 1);
      id_rw_       = $urandom_range(0, 1);
      id_halt      = ($urandom_range(0, 59) == 0);
      id_exception = ($urandom_range(0, 99) == 0);
      redirect     = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      model_eval();
      nchecks++; if (stall !== e_stall) begin nerr++; $display("FAIL rnd_stall@%0d: got %b want %b", n, stall, e_stall); end
      nchecks++; if (bubble !== e_bubble) begin nerr++; $display("FAIL rnd_bubble@%0d: got %b want %b", n, bubble, e_bubble); end
      nchecks++; if (flush !== e_flush) begin nerr++; $display("FAIL rnd_flush@%0d: got %b want %b", n, flush, e_flush); end
      nchecks++; if (halt !== e_halt) begin nerr++; $display("FAIL rnd_halt@%0d: got %b want %b", n, halt, e_halt); end
      nchecks++; if (exception !== e_exc) begin nerr++; $display("FAIL rnd_exc@%0d: got %b want %b", n, exception, e_exc); end
      nchecks++; if (stall_cnt !== CNTB'(exp_cnt)) begin nerr++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, stall_cnt, exp_cnt); end
      @(posedge clk);
      model_commit();
      #1;
    end
  endtask

  initial begin
    set_idle();
    rst_ = 1;
    #1;
    test_reset();
    test_raw();
    test_no_hazard();
    test_redirect();
    test_halt();
    test_exc_both();
    test_halt_in_flush();
    test_reset_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline interlock and sequencing controller for the pipelined cpu3 datapath (IF, ID, EX, MEM, WB).
- Tracks register-file writes in flight past ID.
- Stalls ID on read-after-write hazards and squashes wrong-path instructions after taken branches and jumps.
- Drains the pipeline on halt or exception before asserting the terminal outputs.
- Drives the PC/instruction-register hold and the ID/EX bubble insert.

Parameters:
REG_ADDR_BITS, 5, register address width
DEPTH, 3, number of in-flight stages tracked after ID (EX, MEM, WB)
WB_BYPASS, 1, 1 = regfile writes through in WB, so the oldest slot is ignored for hazards
FLUSH_CYCLES, 2, number of younger instructions squashed after a redirect
CNT_BITS, 16, stall counter width

Ports:
clk  in  1  system clock
rst_  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_r1_addr  in  REG_ADDR_BITS  source 1 address
id_r2_addr  in  REG_ADDR_BITS  source 2 address
id_use_r1  in  1  instruction reads source 1
id_use_r2  in  1  instruction reads source 2
id_rw_  in  1  active-low register write enable of the ID instruction
id_waddr  in  REG_ADDR_BITS  destination address
id_halt  in  1  ID instruction is halt
id_exception  in  1  ID instruction is illegal
redirect  in  1  taken branch, jump, jal or jreg resolved this cycle
stall  out  1  hold PC and instruction register
bubble  out  1  force ID/EX controls to NOP (rw_=1, mem_rw_=1)
flush  out  1  squash the instruction in IF/ID
halt  out  1  sticky, pipeline drained after halt
exception  out  1  sticky, pipeline drained after exception
stall_cnt  out  CNT_BITS  saturating count of stall cycles

Behaviour:
- Reset (async, rst_ low): all slots invalid, state RUN, flush counter 0, stall_cnt 0, and all 1-bit outputs 0. Outputs update only on posedge clk; the reset value takes effect immediately.
- Slot table: DEPTH entries of {v, waddr}, shifted each cycle (slot0 → slot1 → … → slot DEPTH-1, oldest drops).
- Slot0 load value:
  - If the ID instruction issues: v = ~id_rw_ & (id_waddr != 0), waddr = id_waddr.
  - Otherwise: v = 0.
- Issue condition: id_valid & ~stall & ~bubble & state RUN.
- Hazard (combinational): id_valid and, for either source X, id_use_rX, rX_addr != 0, and rX_addr == waddr of any valid slot in the checked range.
  - Checked range is slots 0..DEPTH-1, or 0..DEPTH-2 when WB_BYPASS=1.
  - On hazard: stall=1 and bubble=1. Register 0 never hazards.
- Redirect:
  - In the redirect cycle: flush=1 and bubble=1.
  - The flush counter loads FLUSH_CYCLES-1. While nonzero, it decrements and holds flush=1 and bubble=1.
  - Redirect overrides hazard: stall=0 that cycle. Slot shifting continues.
  - A second redirect while the counter is active reloads it.
- State machine (RUN, DRAIN, DONE):
  - RUN → DRAIN when id_valid & (id_halt | id_exception) & ~flush & ~redirect. A halt or exception in the branch shadow is ignored.
  - A pending-exception flag is latched if id_exception (exception has priority if both are set).
  - DRAIN: stall=1 and bubble=1 every cycle. Go to DONE when all slots are invalid.
  - DONE: stall=1 and bubble=1, and halt or exception is set to 1, sticky until reset.
  - Halt or exception is asserted exactly DEPTH cycles after the halt issues when no writes are pending behind it.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- Reset mid-drain or mid-flush returns immediately to the reset state.

Test Plan:
- Write r3 (id_rw_=0, waddr=3) issued, then the next instruction reads r3 with WB_BYPASS=1 → stall=bubble=1 for exactly 2 cycles, issue on the 3rd; stall_cnt=2.
- Write r0, then read r0 → no stall; a write to r5 followed by a read of r6 → no stall.
- redirect pulse for 1 cycle with FLUSH_CYCLES=2 → flush=1 for 2 cycles, stall=0; a pending hazard in the same cycle is dropped.
- Halt issued with no pending writes → halt=1 on the 3rd cycle after issue and stays 1; exception stays 0; stall=1 from issue onward.
- id_exception=1 and id_halt=1 together → exception=1, halt=0 after drain. Halt presented during flush → ignored, state stays RUN.
- rst_ asserted during DRAIN → halt=0, stall=0, slots clear asynchronously; normal issue resumes after release.
